hpm_counter_unit: RTL and testbench

Parametrised hardware performance monitor that replaces the fixed-function perf counter block. It provides NumCounters generic counters, each with a software-programmable event selector, an inhibit bit, multi-unit per-cycle increments for superscalar commit, and sticky overflow flags with an interrupt output. It sits beside csr_regfile, which drives its SRAM-like access port. Event sources are pre-decoded into per-cycle counts outside the block.

---
 rtl/ariane_pkg.sv | 31 +++
 rtl/cva6_hpm_counter.sv | 50 +++++
 rtl/hpm_counter_unit.sv | 134 +++++++++++++
 tb/tb_hpm_counter_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared types and constants for the hpm counter unit
// Purpose: register-class selector enum and event index constants used by
//          hpm_counter_unit and its software-visible event map.
// Ports:   none (package).
package ariane_pkg;

  typedef enum logic [1:0] {
    HPM_COUNT   = 2'd0,
    HPM_EVENT   = 2'd1,
    HPM_INHIBIT = 2'd2,
    HPM_OVF     = 2'd3
  } hpm_sel_e;

  // Event index 0 never counts; a selector of 0 parks a counter.
  localparam int unsigned EV_NONE        = 0;
  localparam int unsigned EV_ICACHE_MISS = 1;
  localparam int unsigned EV_DCACHE_MISS = 2;
  localparam int unsigned EV_ITLB_MISS   = 3;
  localparam int unsigned EV_DTLB_MISS   = 4;
  localparam int unsigned EV_LOAD        = 5;
  localparam int unsigned EV_STORE       = 6;
  localparam int unsigned EV_BRANCH      = 7;
  localparam int unsigned EV_CALL        = 8;
  localparam int unsigned EV_RET         = 9;
  localparam int unsigned EV_EXCEPTION   = 10;
  localparam int unsigned EV_ERET        = 11;
  localparam int unsigned EV_MISPREDICT  = 12;
  localparam int unsigned EV_SB_FULL     = 13;
  localparam int unsigned EV_IF_EMPTY    = 14;

endpackage

// File: rtl/cva6_hpm_counter.sv
// rtl/cva6_hpm_counter.sv - single performance counter with load and carry-out
// Purpose: one modular up-counter advancing by a multi-unit increment.
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   en_i         count enable for this cycle
//   inc_i        increment amount for this cycle
//   load_i       load strobe; overrides the increment
//   load_data_i  value loaded when load_i is high
//   count_o      current counter value
//   carry_o      increment this cycle carries out of the MSB
module cva6_hpm_counter #(
  parameter int unsigned Width    = 64,
  parameter int unsigned IncWidth = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [IncWidth-1:0] inc_i,
  input  logic                load_i,
  input  logic [Width-1:0]    load_data_i,
  output logic [Width-1:0]    count_o,
  output logic                carry_o
);

  // Wide enough that the increment can never be truncated, even if it is
  // wider than the counter itself.
  localparam int unsigned SumW = ((Width > IncWidth) ? Width : IncWidth) + 1;

  logic [Width-1:0] r_count;
  logic [SumW-1:0]  w_sum;

  assign w_sum = SumW'(r_count) + SumW'(inc_i);

  // A load discards this cycle's increment, so it cannot overflow either.
  assign carry_o = en_i && !load_i && (|w_sum[SumW-1:Width]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (load_i) begin
      r_count <= load_data_i;
    end else if (en_i) begin
      r_count <= w_sum[Width-1:0];
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/hpm_counter_unit.sv
// rtl/hpm_counter_unit.sv - parametrised hardware performance monitor
// Purpose: NumCounters event counters with programmable event selectors,
//          inhibit bits, sticky overflow flags and an overflow interrupt.
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   debug_mode_i  freezes all counting while high
//   addr_i        counter index for COUNT/EVENT access
//   sel_i         register class (COUNT, EVENT, INHIBIT, OVF)
//   we_i          write strobe
//   data_i        write data
//   data_o        combinational read data, zero-extended
//   event_cnt_i   per-event increment for this cycle, IncWidth bits each
//   ovf_irq_en_i  per-counter overflow interrupt enable
//   ovf_irq_o     registered OR of enabled overflow flags
module hpm_counter_unit
  import ariane_pkg::*;
#(
  parameter int unsigned NumCounters  = 8,
  parameter int unsigned CounterWidth = 64,
  parameter int unsigned NumEvents    = 16,
  parameter int unsigned IncWidth     = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          debug_mode_i,
  input  logic [4:0]                    addr_i,
  input  logic [1:0]                    sel_i,
  input  logic                          we_i,
  input  logic [63:0]                   data_i,
  output logic [63:0]                   data_o,
  input  logic [NumEvents*IncWidth-1:0] event_cnt_i,
  input  logic [NumCounters-1:0]        ovf_irq_en_i,
  output logic                          ovf_irq_o
);

  localparam int unsigned EvW = (NumEvents > 1) ? $clog2(NumEvents) : 1;

  hpm_sel_e                w_sel;
  logic [EvW-1:0]          r_evsel [NumCounters];
  logic [NumCounters-1:0]  r_inhibit;
  logic [NumCounters-1:0]  r_ovf;
  logic                    r_irq;
  logic [IncWidth-1:0]     w_inc   [NumCounters];
  logic [CounterWidth-1:0] w_count [NumCounters];
  logic [NumCounters-1:0]  w_load;
  logic [NumCounters-1:0]  w_cnt_en;
  logic [NumCounters-1:0]  w_carry;
  logic [NumCounters-1:0]  w_ovf_clr;
  logic                    w_unused_bits;

  assign w_sel = hpm_sel_e'(sel_i);

  // Upper write-data bits and the event-0 slot are intentionally ignored.
  assign w_unused_bits = ^{data_i, event_cnt_i[IncWidth-1:0]};

  // Selectors of 0 or beyond NumEvents match no slot and yield 0.
  always_comb begin
    for (int i = 0; i < NumCounters; i++) begin
      w_inc[i] = '0;
      for (int unsigned e = EV_NONE + 1; e < NumEvents; e++) begin
        if (r_evsel[i] == EvW'(e)) begin
          w_inc[i] = event_cnt_i[e*IncWidth +: IncWidth];
        end
      end
      w_load[i]   = we_i && (w_sel == HPM_COUNT) && (addr_i == 5'(i));
      w_cnt_en[i] = !debug_mode_i && !r_inhibit[i];
    end
  end

  for (genvar g = 0; g < NumCounters; g++) begin : g_ctr
    cva6_hpm_counter #(
      .Width    (CounterWidth),
      .IncWidth (IncWidth)
    ) u_ctr (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .en_i        (w_cnt_en[g]),
      .inc_i       (w_inc[g]),
      .load_i      (w_load[g]),
      .load_data_i (data_i[CounterWidth-1:0]),
      .count_o     (w_count[g]),
      .carry_o     (w_carry[g])
    );
  end

  assign w_ovf_clr = (we_i && (w_sel == HPM_OVF)) ? data_i[NumCounters-1:0] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumCounters; i++) begin
        r_evsel[i] <= '0;
      end
      r_inhibit <= '0;
      r_ovf     <= '0;
      r_irq     <= 1'b0;
    end else begin
      for (int i = 0; i < NumCounters; i++) begin
        if (we_i && (w_sel == HPM_EVENT) && (addr_i == 5'(i))) begin
          r_evsel[i] <= data_i[EvW-1:0];
        end
      end
      if (we_i && (w_sel == HPM_INHIBIT)) begin
        r_inhibit <= data_i[NumCounters-1:0];
      end
      // Carry is OR-ed after the clear so a coincident overflow survives.
      r_ovf <= (r_ovf & ~w_ovf_clr) | w_carry;
      r_irq <= |(r_ovf & ovf_irq_en_i);
    end
  end

  assign ovf_irq_o = r_irq;

  // Reads see the registered (pre-write) state; unmatched addresses read 0.
  always_comb begin
    data_o = '0;
    case (w_sel)
      HPM_COUNT: begin
        for (int i = 0; i < NumCounters; i++) begin
          if (addr_i == 5'(i)) data_o = 64'(w_count[i]);
        end
      end
      HPM_EVENT: begin
        for (int i = 0; i < NumCounters; i++) begin
          if (addr_i == 5'(i)) data_o = 64'(r_evsel[i]);
        end
      end
      HPM_INHIBIT: data_o = 64'(r_inhibit);
      HPM_OVF:     data_o = 64'(r_ovf);
      default:     data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_hpm_counter_unit.sv
// tb/tb_hpm_counter_unit.sv - self-checking bench for hpm_counter_unit
module tb_hpm_counter_unit;

  localparam int NC = 8;
  localparam int CW = 8;
  localparam int NE = 16;
  localparam int IW = 2;

  logic               clk    = 1'b0;
  logic               rst_n  = 1'b0;
  logic               dbg    = 1'b0;
  logic [4:0]         addr   = '0;
  logic [1:0]         sel    = '0;
  logic               we     = 1'b0;
  logic [63:0]        wdata  = '0;
  logic [63:0]        rdata;
  logic [NE*IW-1:0]   ev     = '0;
  logic [NC-1:0]      irq_en = '0;
  logic               irq;

  hpm_counter_unit #(
    .NumCounters  (NC),
    .CounterWidth (CW),
    .NumEvents    (NE),
    .IncWidth     (IW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .debug_mode_i (dbg),
    .addr_i       (addr),
    .sel_i        (sel),
    .we_i         (we),
    .data_i       (wdata),
    .data_o       (rdata),
    .event_cnt_i  (ev),
    .ovf_irq_en_i (irq_en),
    .ovf_irq_o    (irq)
  );

  always #50 clk = ~clk;

  // Reference model state
  int          m_cnt [NC];
  int          m_ev  [NC];
  logic [NC-1:0] m_inh;
  logic [NC-1:0] m_ovf;
  logic          m_irq;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = 0;
      m_ev[i]  = 0;
    end
    m_inh = '0;
    m_ovf = '0;
    m_irq = 1'b0;
  endtask

  function automatic logic [63:0] mread(input logic [1:0] s, input logic [4:0] a);
    case (s)
      2'd0:    return (a < NC) ? 64'(m_cnt[a]) : 64'd0;
      2'd1:    return (a < NC) ? 64'(m_ev[a]) : 64'd0;
      2'd2:    return 64'(m_inh);
      default: return 64'(m_ovf);
    endcase
  endfunction

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [NC-1:0] carry;
    logic [NC-1:0] clr;
    int nxt [NC];
    int inc;
    int s;
    carry = '0;
    m_irq = |(m_ovf & irq_en);
    for (int i = 0; i < NC; i++) begin
      inc = (m_ev[i] > 0 && m_ev[i] < NE) ? int'((ev >> (m_ev[i] * IW)) & 32'd3) : 0;
      nxt[i] = m_cnt[i];
      if (we && sel == 2'd0 && addr == i) begin
        nxt[i] = int'(wdata[CW-1:0]);
      end else if (!dbg && !m_inh[i]) begin
        s = m_cnt[i] + inc;
        carry[i] = (s >= (1 << CW));
        nxt[i] = s % (1 << CW);
      end
    end
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = nxt[i];
      if (we && sel == 2'd1 && addr == i) m_ev[i] = int'(wdata[3:0]);
    end
    if (we && sel == 2'd2) m_inh = wdata[NC-1:0];
    clr = (we && sel == 2'd3) ? wdata[NC-1:0] : '0;
    m_ovf = (m_ovf & ~clr) | carry;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [1:0] s, input logic [4:0] a, input logic [63:0] exp);
    sel  = s;
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic wr(input logic [1:0] s, input logic [4:0] a, input logic [63:0] d);
    sel   = s;
    addr  = a;
    wdata = d;
    we    = 1'b1;
    #1;
    chk("prewrite_read", rdata, mread(s, a));
    tick();
    we = 1'b0;
  endtask

  task automatic check_all_model(input string tag);
    for (int i = 0; i < NC; i++) begin
      rd(tag, 2'd0, 5'(i), mread(2'd0, 5'(i)));
      rd(tag, 2'd1, 5'(i), mread(2'd1, 5'(i)));
    end
    rd(tag, 2'd2, 5'd0, mread(2'd2, 5'd0));
    rd(tag, 2'd3, 5'd0, mread(2'd3, 5'd0));
    chk({tag, "_irq"}, 64'(irq), 64'(m_irq));
  endtask

  initial begin
    logic [4:0] ra;
    model_reset();

    // Reset: every register reads zero
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < NC; i++) begin
      rd("rst_count", 2'd0, 5'(i), 64'd0);
      rd("rst_event", 2'd1, 5'(i), 64'd0);
    end
    rd("rst_inhibit", 2'd2, 5'd0, 64'd0);
    rd("rst_ovf", 2'd3, 5'd0, 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);

    // All events active but every selector is 0
    ev = '1;
    repeat (10) tick();
    for (int i = 0; i < NC; i++) rd("evsel0_idle", 2'd0, 5'(i), 64'd0);

    // Event 5 at 2 per cycle into counter 2, then inhibit
    ev = '0;
    wr(2'd1, 5'd2, 64'd5);
    ev = 32'h0000_0800;
    repeat (7) tick();
    rd("cnt2_after_7", 2'd0, 5'd2, 64'd14);
    ev = '0;
    wr(2'd2, 5'd0, 64'h4);
    ev = 32'h0000_0800;
    repeat (5) tick();
    rd("cnt2_inhibited", 2'd0, 5'd2, 64'd14);

    // Wrap with overflow and interrupt
    ev = '0;
    wr(2'd2, 5'd0, 64'h0);
    wr(2'd0, 5'd0, 64'hFE);
    wr(2'd1, 5'd0, 64'd1);
    irq_en = 8'h01;
    ev = 32'h0000_000C;
    tick();
    rd("wrap_count", 2'd0, 5'd0, 64'h01);
    rd("wrap_ovf", 2'd3, 5'd0, 64'h01);
    chk("irq_latency0", 64'(irq), 64'd0);
    ev = '0;
    tick();
    chk("irq_asserted", 64'(irq), 64'd1);
    wr(2'd3, 5'd0, 64'h1);
    rd("ovf_cleared", 2'd3, 5'd0, 64'h0);
    chk("irq_hold", 64'(irq), 64'd1);
    tick();
    chk("irq_dropped", 64'(irq), 64'd0);

    // Load wins over same-cycle increment
    wr(2'd1, 5'd1, 64'd1);
    ev = 32'h0000_0008;
    wr(2'd0, 5'd1, 64'd100);
    rd("load_drops_inc", 2'd0, 5'd1, 64'd100);
    tick();
    rd("post_load_inc", 2'd0, 5'd1, 64'd102);

    // Debug freeze; writes still land
    dbg = 1'b1;
    repeat (4) tick();
    rd("debug_frozen", 2'd0, 5'd1, 64'd102);
    wr(2'd0, 5'd1, 64'd7);
    rd("debug_write", 2'd0, 5'd1, 64'd7);
    dbg = 1'b0;
    ev  = '0;

    // Out-of-range address
    wr(2'd0, 5'd31, 64'h55);
    rd("addr31_count", 2'd0, 5'd31, 64'd0);
    rd("addr31_event", 2'd1, 5'd31, 64'd0);
    check_all_model("addr31_nochange");

    // OVF clear racing a new overflow
    wr(2'd0, 5'd0, 64'hFF);
    ev = 32'h0000_0004;
    tick();
    rd("ovf_set_again", 2'd3, 5'd0, mread(2'd3, 5'd0));
    chk("ovf_set_bit0", 64'(rdata[0]), 64'd1);
    ev = '0;
    wr(2'd0, 5'd0, 64'hFF);
    ev = 32'h0000_0004;
    wr(2'd3, 5'd0, 64'h1);
    rd("ovf_race", 2'd3, 5'd0, mread(2'd3, 5'd0));
    chk("ovf_race_bit0", 64'(rdata[0]), 64'd1);
    ev = '0;

    // Randomised traffic against the model
    for (int c = 0; c < 300; c++) begin
      check_all_model("rnd");
      if (c == 150) begin
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NC; i++) rd("async_rst_count", 2'd0, 5'(i), 64'd0);
        rd("async_rst_ovf", 2'd3, 5'd0, 64'd0);
        chk("async_rst_irq", 64'(irq), 64'd0);
        model_reset();
        rst_n = 1'b1;
        #1;
      end
      ev  = $urandom;
      dbg = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) irq_en = NC'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        ra = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
        wr(2'($urandom_range(0, 3)), ra, {$urandom, $urandom});
      end else begin
        tick();
      end
    end
    check_all_model("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
